// File: rtl/classificador_cores_face_pkg.sv
// rtl/classificador_cores_face_pkg.sv - colour codes, FSM states and cores field helper
package classificador_cores_face_pkg;

    localparam logic [2:0] COR_BRANCO     = 3'd0;
    localparam logic [2:0] COR_AMARELO    = 3'd1;
    localparam logic [2:0] COR_VERMELHO   = 3'd2;
    localparam logic [2:0] COR_LARANJA    = 3'd3;
    localparam logic [2:0] COR_VERDE      = 3'd4;
    localparam logic [2:0] COR_AZUL       = 3'd5;
    localparam logic [2:0] COR_INDEFINIDO = 3'd7;

    localparam int N_QUADRANTES = 9;

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        ACUMULA    = 2'd1,
        CLASSIFICA = 2'd2,
        PRONTO     = 2'd3
    } estado_t;

    // LSB of quadrant q's 3-bit field inside cores
    function automatic int campo_lsb(input logic [3:0] q);
        return 3 * int'(q);
    endfunction

endpackage

// File: rtl/classificador_cores_face_cor.sv
// rtl/classificador_cores_face_cor.sv - combinational average-RGB to colour code classifier
module classificador_cor
    import classificador_cores_face_pkg::*;
#(
    parameter int LIM_ALTO  = 20,
    parameter int LIM_BAIXO = 10
) (
    input  logic [4:0] r,
    input  logic [4:0] g,
    input  logic [4:0] b,
    input  logic       completo,
    output logic [2:0] codigo
);

    localparam logic [4:0] ALTO  = 5'(LIM_ALTO);
    localparam logic [4:0] BAIXO = 5'(LIM_BAIXO);

    logic r_alto, g_alto, b_alto, r_baixo, g_medio;

    always_comb begin
        r_alto  = (r >= ALTO);
        g_alto  = (g >= ALTO);
        b_alto  = (b >= ALTO);
        r_baixo = (r < BAIXO);
        g_medio = (g >= BAIXO);

        // Rule order matters: earlier rules shadow later ones
        codigo = COR_INDEFINIDO;
        if (!completo)                  codigo = COR_INDEFINIDO;
        else if (r_alto && g_alto && b_alto) codigo = COR_BRANCO;
        else if (b_alto && r_baixo)     codigo = COR_AZUL;
        else if (g_alto && r_baixo)     codigo = COR_VERDE;
        else if (r_alto && g_alto)      codigo = COR_AMARELO;
        else if (r_alto && g_medio)     codigo = COR_LARANJA;
        else if (r_alto)                codigo = COR_VERMELHO;
    end

endmodule

// File: rtl/classificador_cores_face.sv
// rtl/classificador_cores_face.sv - per-quadrant RGB565 averaging and cube colour classification
module classificador_cores_face
    import classificador_cores_face_pkg::*;
#(
    parameter int K         = 8,
    parameter int LIM_ALTO  = 20,
    parameter int LIM_BAIXO = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
    input  logic        pixel_valido,
    input  logic [15:0] pixel,
    input  logic [3:0]  quadrante,
    input  logic        fim_frame,
    output logic        pronto,
    output logic [26:0] cores,
    output logic [3:0]  db_estado
);

    localparam int WR = 5 + K;
    localparam int WG = 6 + K;
    localparam int WC = K + 1;

    estado_t       estado_q, estado_d;
    logic [3:0]    idx_q, idx_d;
    logic          pronto_q, pronto_d;
    logic [26:0]   cores_q, cores_d;
    logic [WR-1:0] soma_r_q [N_QUADRANTES];
    logic [WR-1:0] soma_r_d [N_QUADRANTES];
    logic [WG-1:0] soma_g_q [N_QUADRANTES];
    logic [WG-1:0] soma_g_d [N_QUADRANTES];
    logic [WR-1:0] soma_b_q [N_QUADRANTES];
    logic [WR-1:0] soma_b_d [N_QUADRANTES];
    logic [WC-1:0] cnt_q    [N_QUADRANTES];
    logic [WC-1:0] cnt_d    [N_QUADRANTES];

    logic [4:0] media_r, media_g, media_b;
    logic       completo;
    logic [2:0] codigo;

    // Average = sum >> K; green carries 6 bits, so one more shift brings it to 5
    always_comb begin
        media_r  = soma_r_q[idx_q][K +: 5];
        media_g  = soma_g_q[idx_q][K + 1 +: 5];
        media_b  = soma_b_q[idx_q][K +: 5];
        completo = cnt_q[idx_q][K];
    end

    classificador_cor #(
        .LIM_ALTO  (LIM_ALTO),
        .LIM_BAIXO (LIM_BAIXO)
    ) u_cor (
        .r        (media_r),
        .g        (media_g),
        .b        (media_b),
        .completo (completo),
        .codigo   (codigo)
    );

    always_comb begin
        estado_d = estado_q;
        idx_d    = idx_q;
        pronto_d = pronto_q;
        cores_d  = cores_q;
        for (int q = 0; q < N_QUADRANTES; q++) begin
            soma_r_d[q] = soma_r_q[q];
            soma_g_d[q] = soma_g_q[q];
            soma_b_d[q] = soma_b_q[q];
            cnt_d[q]    = cnt_q[q];
        end

        if (iniciar) begin
            estado_d = ACUMULA;
            idx_d    = 4'd0;
            pronto_d = 1'b0;
            for (int q = 0; q < N_QUADRANTES; q++) begin
                soma_r_d[q] = '0;
                soma_g_d[q] = '0;
                soma_b_d[q] = '0;
                cnt_d[q]    = '0;
            end
        end else begin
            unique case (estado_q)
                ACUMULA: begin
                    for (int q = 0; q < N_QUADRANTES; q++) begin
                        if (pixel_valido && quadrante == 4'(q) && !cnt_q[q][K]) begin
                            soma_r_d[q] = soma_r_q[q] + WR'(pixel[15:11]);
                            soma_g_d[q] = soma_g_q[q] + WG'(pixel[10:5]);
                            soma_b_d[q] = soma_b_q[q] + WR'(pixel[4:0]);
                            cnt_d[q]    = cnt_q[q] + WC'(1);
                        end
                    end
                    if (fim_frame) begin
                        estado_d = CLASSIFICA;
                        idx_d    = 4'd0;
                    end
                end
                CLASSIFICA: begin
                    cores_d[campo_lsb(idx_q) +: 3] = codigo;
                    if (idx_q == 4'(N_QUADRANTES - 1)) begin
                        estado_d = PRONTO;
                        pronto_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= OCIOSO;
            idx_q    <= 4'd0;
            pronto_q <= 1'b0;
            cores_q  <= '1;
            for (int q = 0; q < N_QUADRANTES; q++) begin
                soma_r_q[q] <= '0;
                soma_g_q[q] <= '0;
                soma_b_q[q] <= '0;
                cnt_q[q]    <= '0;
            end
        end else begin
            estado_q <= estado_d;
            idx_q    <= idx_d;
            pronto_q <= pronto_d;
            cores_q  <= cores_d;
            for (int q = 0; q < N_QUADRANTES; q++) begin
                soma_r_q[q] <= soma_r_d[q];
                soma_g_q[q] <= soma_g_d[q];
                soma_b_q[q] <= soma_b_d[q];
                cnt_q[q]    <= cnt_d[q];
            end
        end
    end

    assign pronto    = pronto_q;
    assign cores     = cores_q;
    assign db_estado = {2'b00, estado_q};

endmodule
